// File: rtl/lc3_io_pkg.sv
// -----------------------------------------------------------------------------
// lc3_io_pkg
// Shared definitions for the LC-3 memory-mapped I/O devices: register
// addresses, status bit positions and the access decode used by the
// keyboard (and later display) register blocks.
// -----------------------------------------------------------------------------
package lc3_io_pkg;

  localparam logic [15:0] KBSR_ADDR      = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR      = 16'hFE02;
  localparam int          KBSR_READY_BIT = 15;
  localparam int          KBSR_IE_BIT    = 14;

  // Which device register (if any) the current bus cycle targets.
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_KBSR = 2'd1,
    ACC_KBDR = 2'd2
  } kbd_acc_e;

  function automatic kbd_acc_e kbd_decode(input logic        mio_en,
                                          input logic [15:0] addr);
    kbd_acc_e acc;
    acc = ACC_NONE;
    if (mio_en) begin
      if (addr == KBSR_ADDR)      acc = ACC_KBSR;
      else if (addr == KBDR_ADDR) acc = ACC_KBDR;
    end
    return acc;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// -----------------------------------------------------------------------------
// kbd_fifo
// DEPTH x 8 synchronous FIFO buffering keyboard characters.
//   clk     in   system clock
//   reset   in   synchronous active-high reset (empties the FIFO)
//   push_i  in   write wdata_i at tail (ignored when full)
//   wdata_i in   character to store
//   pop_i   in   advance head (ignored when empty)
//   head_o  out  character at head (valid when !empty_o)
//   full_o  out  DEPTH entries held
//   empty_o out  no entries held
//   count_o out  number of entries held
// -----------------------------------------------------------------------------
module kbd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [7:0]                 wdata_i,
  input  logic                       pop_i,
  output logic [7:0]                 head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lc3_kbd_in.sv
// -----------------------------------------------------------------------------
// lc3_kbd_in
// LC-3 memory-mapped keyboard input device. Characters arrive on a
// valid/ready stream, are buffered in kbd_fifo, and are read by the CPU
// through KBSR (status/interrupt enable) and KBDR (data).
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   key_data  in   ASCII character from host
//   key_valid in   key_data valid
//   key_ready out  device accepts a character this cycle
//   mio_en    in   memory/IO access strobe
//   r_w       in   1 = write, 0 = read
//   addr      in   access address
//   data_in   in   CPU write data
//   data_out  out  registered read data, held between accesses
//   hit       out  previous cycle's access targeted KBSR or KBDR
//   intr_req  out  character pending and interrupts enabled
//   overrun   out  sticky: a KBDR read found the FIFO empty
// -----------------------------------------------------------------------------
module lc3_kbd_in
  import lc3_io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  key_data,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        hit,
  output logic        intr_req,
  output logic        overrun
);

  logic [15:0] data_out_q, data_out_d;
  logic        hit_q, hit_d;
  logic        ie_q, ie_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  last_char_q, last_char_d;

  logic        fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [7:0]  fifo_head;
  logic [$clog2(DEPTH):0] unused_count;
  logic        unused_wdata;
  kbd_acc_e    acc;
  logic [15:0] status;

  assign key_ready = !fifo_full && !reset;
  assign fifo_push = key_valid && key_ready;

  kbd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (key_data),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_count)
  );

  // Only the IE and overrun-clear bits of a KBSR write carry meaning.
  assign unused_wdata = ^{data_in[15], data_in[13:1]};

  always_comb begin
    status                 = '0;
    status[KBSR_READY_BIT] = !fifo_empty;
    status[KBSR_IE_BIT]    = ie_q;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    acc         = kbd_decode(mio_en, addr);
    data_out_d  = data_out_q;
    hit_d       = (acc != ACC_NONE);
    ie_d        = ie_q;
    overrun_d   = overrun_q;
    last_char_d = last_char_q;
    fifo_pop    = 1'b0;
    case (acc)
      ACC_KBSR: begin
        if (r_w) begin
          ie_d = data_in[KBSR_IE_BIT];
          if (data_in[0]) overrun_d = 1'b0;
        end else begin
          data_out_d = status;
        end
      end
      ACC_KBDR: begin
        // Writes to KBDR are ignored apart from asserting hit.
        if (!r_w) begin
          // Emptiness is judged before the edge: a character pushed in this
          // same cycle is not returned and the read counts as an overrun.
          if (!fifo_empty) begin
            data_out_d  = {8'h00, fifo_head};
            last_char_d = fifo_head;
            fifo_pop    = 1'b1;
          end else begin
            data_out_d = {8'h00, last_char_q};
            overrun_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q  <= '0;
      hit_q       <= 1'b0;
      ie_q        <= 1'b0;
      overrun_q   <= 1'b0;
      last_char_q <= 8'h00;
    end else begin
      data_out_q  <= data_out_d;
      hit_q       <= hit_d;
      ie_q        <= ie_d;
      overrun_q   <= overrun_d;
      last_char_q <= last_char_d;
    end
  end

  assign data_out = data_out_q;
  assign hit      = hit_q;
  assign overrun  = overrun_q;
  assign intr_req = ie_q && !fifo_empty;

endmodule
